// File: rtl/sr_mul_pkg.sv
// Shared op encodings and width helpers for the sr_mul_pipe multiplier.
// Used by sr_mul_pipe and sr_mul_stage.
package sr_mul_pkg;

    typedef enum logic [1:0] {
        MUL_OP_MUL    = 2'b00,
        MUL_OP_MULH   = 2'b01,
        MUL_OP_MULHSU = 2'b10,
        MUL_OP_MULHU  = 2'b11
    } mul_op_t;

    // Full product of two (width+1)-bit signed operands.
    function automatic int unsigned prod_width(int unsigned width);
        return 2 * width + 2;
    endfunction

    function automatic logic op_a_signed(mul_op_t op);
        return (op == MUL_OP_MULH) || (op == MUL_OP_MULHSU);
    endfunction

    function automatic logic op_b_signed(mul_op_t op);
        return op == MUL_OP_MULH;
    endfunction

endpackage

// File: rtl/sr_mul_stage.sv
// One pipeline register slice of sr_mul_pipe: valid, tag, op and product.
// Holds when adv is low; flush clears only the valid bit.
module sr_mul_stage
    import sr_mul_pkg::*;
#(
    parameter int unsigned TAG_W  = 5,
    parameter int unsigned PROD_W = 66
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              adv,
    input  logic              in_valid,
    input  logic [TAG_W-1:0]  in_tag,
    input  mul_op_t           in_op,
    input  logic [PROD_W-1:0] in_prod,
    output logic              out_valid,
    output logic [TAG_W-1:0]  out_tag,
    output mul_op_t           out_op,
    output logic [PROD_W-1:0] out_prod
);

    logic              valid_q;
    logic [TAG_W-1:0]  tag_q;
    mul_op_t           op_q;
    logic [PROD_W-1:0] prod_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
            op_q    <= MUL_OP_MUL;
            prod_q  <= '0;
        end else begin
            if (flush) begin
                valid_q <= 1'b0;
            end else if (adv) begin
                valid_q <= in_valid;
            end
            // Bubbles leave the data registers untouched.
            if (adv && in_valid) begin
                tag_q  <= in_tag;
                op_q   <= in_op;
                prod_q <= in_prod;
            end
        end
    end

    assign out_valid = valid_q;
    assign out_tag   = tag_q;
    assign out_op    = op_q;
    assign out_prod  = prod_q;

endmodule

// File: rtl/sr_mul_pipe.sv
// Elastic pipelined RV32M multiplier with flush, tag passthrough and per-stage visibility.
// Define SR_MUL_HIGH_EN to support MULH/MULHSU/MULHU; otherwise every op is MUL.
module sr_mul_pipe
    import sr_mul_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 2,
    parameter int unsigned TAG_W  = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [1:0]               in_op,
    input  logic [WIDTH-1:0]         in_a,
    input  logic [WIDTH-1:0]         in_b,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_result,
    output logic [TAG_W-1:0]         out_tag,
    output logic [STAGES-1:0]        stage_valid,
    output logic [STAGES*TAG_W-1:0]  stage_tag,
    output logic                     busy
);

`ifdef SR_MUL_HIGH_EN
    localparam int unsigned PROD_W = prod_width(WIDTH);
`else
    localparam int unsigned PROD_W = WIDTH;
`endif
    localparam int unsigned LAST = STAGES - 1;

    logic              adv;
    mul_op_t           op_in;
    logic [PROD_W-1:0] prod_d;

    logic              s_valid [STAGES];
    logic [TAG_W-1:0]  s_tag   [STAGES];
    mul_op_t           s_op    [STAGES];
    logic [PROD_W-1:0] s_prod  [STAGES];

    logic              valid0_q;
    logic [TAG_W-1:0]  tag0_q;
    mul_op_t           op0_q;
    logic [PROD_W-1:0] prod0_q;

    // Global stall: everything moves only when the last stage can drain.
    assign adv      = !s_valid[LAST] || out_ready;
    assign in_ready = adv || !rst_n;

`ifdef SR_MUL_HIGH_EN
    logic [PROD_W-1:0] ext_a;
    logic [PROD_W-1:0] ext_b;

    assign op_in = mul_op_t'(in_op);

    // Low PROD_W bits of the product of sign-extended operands equal the exact signed product.
    always_comb begin
        ext_a  = {{(PROD_W - WIDTH){op_a_signed(op_in) & in_a[WIDTH-1]}}, in_a};
        ext_b  = {{(PROD_W - WIDTH){op_b_signed(op_in) & in_b[WIDTH-1]}}, in_b};
        prod_d = ext_a * ext_b;
    end
`else
    logic unused_op;

    assign op_in     = MUL_OP_MUL;
    assign unused_op = ^in_op;

    always_comb begin
        prod_d = in_a * in_b;
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid0_q <= 1'b0;
            tag0_q   <= '0;
            op0_q    <= MUL_OP_MUL;
            prod0_q  <= '0;
        end else begin
            if (flush) begin
                valid0_q <= 1'b0;
            end else if (adv) begin
                valid0_q <= in_valid;
            end
            if (adv && in_valid) begin
                tag0_q  <= in_tag;
                op0_q   <= op_in;
                prod0_q <= prod_d;
            end
        end
    end

    assign s_valid[0] = valid0_q;
    assign s_tag[0]   = tag0_q;
    assign s_op[0]    = op0_q;
    assign s_prod[0]  = prod0_q;

    for (genvar i = 1; i < int'(STAGES); i++) begin : g_stage
        sr_mul_stage #(
            .TAG_W  (TAG_W),
            .PROD_W (PROD_W)
        ) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .flush     (flush),
            .adv       (adv),
            .in_valid  (s_valid[i-1]),
            .in_tag    (s_tag[i-1]),
            .in_op     (s_op[i-1]),
            .in_prod   (s_prod[i-1]),
            .out_valid (s_valid[i]),
            .out_tag   (s_tag[i]),
            .out_op    (s_op[i]),
            .out_prod  (s_prod[i])
        );
    end

`ifdef SR_MUL_HIGH_EN
    logic unused_prod_hi;

    assign unused_prod_hi = ^s_prod[LAST][PROD_W-1:2*WIDTH];
    assign out_result = (s_op[LAST] == MUL_OP_MUL) ? s_prod[LAST][WIDTH-1:0]
                                                   : s_prod[LAST][2*WIDTH-1:WIDTH];
`else
    logic unused_last_op;

    assign unused_last_op = ^s_op[LAST];
    assign out_result     = s_prod[LAST];
`endif

    assign out_valid = s_valid[LAST];
    assign out_tag   = s_tag[LAST];

    always_comb begin
        stage_valid = '0;
        stage_tag   = '0;
        for (int i = 0; i < int'(STAGES); i++) begin
            stage_valid[i]               = s_valid[i];
            stage_tag[i*TAG_W +: TAG_W]  = s_tag[i];
        end
    end

    assign busy = |stage_valid;

endmodule

// File: tb/tb_sr_mul_pipe.sv
// Self-checking bench for sr_mul_pipe: main STAGES=2 instance plus STAGES=1/4 latency instances.
// Honours SR_MUL_HIGH_EN in its reference model.
module tb_sr_mul_pipe;

    localparam int unsigned W  = 32;
    localparam int unsigned TW = 5;
    localparam int unsigned SM = 2;

    logic          clk = 1'b0;
    logic          rst_n, flush, in_valid, out_ready;
    logic [1:0]    in_op;
    logic [W-1:0]  in_a, in_b;
    logic [TW-1:0] in_tag;

    logic             in_ready, out_valid, busy;
    logic [W-1:0]     out_result;
    logic [TW-1:0]    out_tag;
    logic [SM-1:0]    stage_valid;
    logic [SM*TW-1:0] stage_tag;

    logic          a1_in_ready, a1_out_valid, a1_busy;
    logic [W-1:0]  a1_out_result;
    logic [TW-1:0] a1_out_tag;
    logic [0:0]    a1_stage_valid;
    logic [TW-1:0] a1_stage_tag;

    logic            a4_in_ready, a4_out_valid, a4_busy;
    logic [W-1:0]    a4_out_result;
    logic [TW-1:0]   a4_out_tag;
    logic [3:0]      a4_stage_valid;
    logic [4*TW-1:0] a4_stage_tag;

    int n_cmp = 0;
    int n_err = 0;

    // Reference pipeline: one slot per stage, slot SM-1 is the output.
    logic          m_v [SM];
    logic [W-1:0]  m_r [SM];
    logic [TW-1:0] m_t [SM];

    always #5 clk = ~clk;

    sr_mul_pipe #(.WIDTH(W), .STAGES(SM), .TAG_W(TW)) u_dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .out_valid(out_valid),
        .out_ready(out_ready), .out_result(out_result), .out_tag(out_tag),
        .stage_valid(stage_valid), .stage_tag(stage_tag), .busy(busy)
    );

    sr_mul_pipe #(.WIDTH(W), .STAGES(1), .TAG_W(TW)) u_dut_s1 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(a1_in_ready),
        .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .out_valid(a1_out_valid),
        .out_ready(out_ready), .out_result(a1_out_result), .out_tag(a1_out_tag),
        .stage_valid(a1_stage_valid), .stage_tag(a1_stage_tag), .busy(a1_busy)
    );

    sr_mul_pipe #(.WIDTH(W), .STAGES(4), .TAG_W(TW)) u_dut_s4 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(a4_in_ready),
        .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .out_valid(a4_out_valid),
        .out_ready(out_ready), .out_result(a4_out_result), .out_tag(a4_out_tag),
        .stage_valid(a4_stage_valid), .stage_tag(a4_stage_tag), .busy(a4_busy)
    );

    function automatic logic [W-1:0] ref_mul(logic [1:0] op, logic [W-1:0] a, logic [W-1:0] b);
        longint     sa, sb;
        logic [63:0] p;
`ifdef SR_MUL_HIGH_EN
        sa = (op == 2'b01 || op == 2'b10) ? longint'($signed(a)) : longint'({32'b0, a});
        sb = (op == 2'b01) ? longint'($signed(b)) : longint'({32'b0, b});
        p  = 64'(sa * sb);
        return (op == 2'b00) ? p[31:0] : p[63:32];
`else
        sa = longint'({32'b0, a});
        sb = longint'({32'b0, b});
        p  = 64'(sa * sb);
        return p[31:0];
`endif
    endfunction

    function automatic logic [SM-1:0] m_vec();
        logic [SM-1:0] v;
        for (int i = 0; i < int'(SM); i++) v[i] = m_v[i];
        return v;
    endfunction

    // Advance one clock edge, updating the reference model from the driven inputs.
    task automatic tick();
        logic adv;
        adv = !m_v[SM-1] || out_ready;
        @(posedge clk);
        if (!rst_n) begin
            for (int i = 0; i < int'(SM); i++) begin
                m_v[i] = 1'b0; m_r[i] = '0; m_t[i] = '0;
            end
        end else if (flush) begin
            for (int i = 0; i < int'(SM); i++) m_v[i] = 1'b0;
        end else if (adv) begin
            for (int i = int'(SM) - 1; i > 0; i--) begin
                m_v[i] = m_v[i-1]; m_r[i] = m_r[i-1]; m_t[i] = m_t[i-1];
            end
            m_v[0] = in_valid;
            m_r[0] = ref_mul(in_op, in_a, in_b);
            m_t[0] = in_tag;
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        in_op = 2'b00; in_a = 32'd5; in_b = 32'd5; in_tag = 5'd7;
        tick(); tick();
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        n_cmp++;
        if (stage_valid !== '0 || out_valid !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_valid: sv=%b ov=%b busy=%b want 0", stage_valid, out_valid, busy);
        end
        n_cmp++;
        if (out_result !== '0 || out_tag !== '0 || stage_tag !== '0) begin
            n_err++;
            $display("FAIL reset_data: res=%h tag=%h st=%h want 0", out_result, out_tag, stage_tag);
        end
        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        tick();
        n_cmp++;
        if (stage_valid !== '0 || a1_out_valid !== 1'b0 || a4_stage_valid !== '0) begin
            n_err++;
            $display("FAIL reset_release: sv=%b a1=%b a4=%b want 0", stage_valid, a1_out_valid,
                     a4_stage_valid);
        end
    endtask

    task automatic test_latency();
        int lat1, lat2, lat4;
        lat1 = 0; lat2 = 0; lat4 = 0;
        out_ready = 1'b1; flush = 1'b0;
        in_valid = 1'b1; in_op = 2'b00; in_a = 32'd7; in_b = 32'd6; in_tag = 5'd3;
        tick();
        in_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            if (a1_out_valid && lat1 == 0) begin
                lat1 = k; n_cmp++;
                if (a1_out_result !== 32'd42 || a1_out_tag !== 5'd3) begin
                    n_err++;
                    $display("FAIL lat_s1_data: res=%0d tag=%0d want 42/3", a1_out_result, a1_out_tag);
                end
            end
            if (out_valid && lat2 == 0) begin
                lat2 = k; n_cmp++;
                if (out_result !== 32'd42 || out_tag !== 5'd3) begin
                    n_err++;
                    $display("FAIL lat_s2_data: res=%0d tag=%0d want 42/3", out_result, out_tag);
                end
            end
            if (a4_out_valid && lat4 == 0) begin
                lat4 = k; n_cmp++;
                if (a4_out_result !== 32'd42 || a4_out_tag !== 5'd3) begin
                    n_err++;
                    $display("FAIL lat_s4_data: res=%0d tag=%0d want 42/3", a4_out_result, a4_out_tag);
                end
            end
            tick();
        end
        n_cmp++;
        if (lat1 != 1) begin n_err++; $display("FAIL lat_s1: got %0d want 1", lat1); end
        n_cmp++;
        if (lat2 != 2) begin n_err++; $display("FAIL lat_s2: got %0d want 2", lat2); end
        n_cmp++;
        if (lat4 != 4) begin n_err++; $display("FAIL lat_s4: got %0d want 4", lat4); end
    endtask

    task automatic test_ops();
        logic [1:0]   ops [6] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b11, 2'b00};
        logic [W-1:0] va  [6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                  32'hFFFF_FFFF, 32'd7};
        logic [W-1:0] vb  [6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                  32'd2, 32'd6};
`ifdef SR_MUL_HIGH_EN
        logic [W-1:0] vexp [6] = '{32'h1, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1, 32'd42};
`else
        logic [W-1:0] vexp [6] = '{32'h1, 32'h1, 32'h1, 32'h1, 32'hFFFF_FFFE, 32'd42};
`endif
        logic [W-1:0] got [$];
        out_ready = 1'b1; flush = 1'b0;
        for (int i = 0; i < 10; i++) begin
            in_valid = (i < 6);
            if (i < 6) begin
                in_op = ops[i]; in_a = va[i]; in_b = vb[i]; in_tag = 5'(i + 16);
            end
            tick();
            if (out_valid) got.push_back(out_result);
        end
        in_valid = 1'b0;
        n_cmp++;
        if (got.size() != 6) begin
            n_err++; $display("FAIL ops_count: got %0d want 6", got.size());
        end
        for (int i = 0; i < 6 && i < got.size(); i++) begin
            n_cmp++;
            if (got[i] !== vexp[i]) begin
                n_err++; $display("FAIL ops_%0d: got %h want %h", i, got[i], vexp[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0]  pa [5];
        logic [W-1:0]  pb [5];
        logic [1:0]    po [5];
        logic [TW-1:0] tags [$];
        logic [W-1:0]  prev_res;
        logic [TW-1:0] prev_tag;
        logic          exp_rdy, stall;
        int            idx, cyc;
        for (int i = 0; i < 5; i++) begin
            pa[i] = $urandom; pb[i] = $urandom; po[i] = 2'($urandom);
        end
        idx = 0; cyc = 1; flush = 1'b0;
        while ((idx < 5 || m_vec() != '0) && cyc < 40) begin
            in_valid = (idx < 5);
            if (idx < 5) begin
                in_op = po[idx]; in_a = pa[idx]; in_b = pb[idx]; in_tag = 5'(idx + 1);
            end
            out_ready = !(cyc >= 2 && cyc <= 5);
            #1;
            exp_rdy = !m_v[SM-1] || out_ready;
            n_cmp++;
            if (in_ready !== exp_rdy) begin
                n_err++; $display("FAIL bp_in_ready c%0d: got %b want %b", cyc, in_ready, exp_rdy);
            end
            stall = out_valid && !out_ready;
            prev_res = out_result; prev_tag = out_tag;
            if (out_valid && out_ready) tags.push_back(out_tag);
            tick();
            if (in_valid && exp_rdy) idx++;
            n_cmp++;
            if (out_valid !== m_v[SM-1] || (m_v[SM-1] && (out_result !== m_r[SM-1] ||
                out_tag !== m_t[SM-1]))) begin
                n_err++;
                $display("FAIL bp_out c%0d: v=%b res=%h tag=%0d want v=%b res=%h tag=%0d", cyc,
                         out_valid, out_result, out_tag, m_v[SM-1], m_r[SM-1], m_t[SM-1]);
            end
            if (stall) begin
                n_cmp++;
                if (out_result !== prev_res || out_tag !== prev_tag) begin
                    n_err++;
                    $display("FAIL bp_stable c%0d: res=%h tag=%0d want %h/%0d", cyc, out_result,
                             out_tag, prev_res, prev_tag);
                end
            end
            cyc++;
        end
        n_cmp++;
        if (tags.size() != 5) begin
            n_err++; $display("FAIL bp_count: got %0d want 5", tags.size());
        end
        for (int i = 0; i < 5 && i < tags.size(); i++) begin
            n_cmp++;
            if (tags[i] !== 5'(i + 1)) begin
                n_err++; $display("FAIL bp_order_%0d: got %0d want %0d", i, tags[i], i + 1);
            end
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b1; flush = 1'b0; in_valid = 1'b1; in_op = 2'b00;
        in_a = 32'd11; in_b = 32'd13; in_tag = 5'd10;
        tick();
        in_tag = 5'd11;
        tick();
        n_cmp++;
        if (stage_valid !== 2'b11) begin
            n_err++; $display("FAIL flush_pre: sv=%b want 11", stage_valid);
        end
        flush = 1'b1; in_tag = 5'd12;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        n_cmp++;
        if (stage_valid !== '0 || busy !== 1'b0 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL flush_clear: sv=%b busy=%b ov=%b want 0", stage_valid, busy, out_valid);
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            n_cmp++;
            if (out_valid !== 1'b0) begin
                n_err++; $display("FAIL flush_ghost_%0d: ov=%b tag=%0d want 0", k, out_valid, out_tag);
            end
        end
    endtask

    task automatic test_reset_midop();
        int lat;
        lat = 0;
        out_ready = 1'b0; flush = 1'b0; in_valid = 1'b1; in_op = 2'b00;
        in_a = 32'd9; in_b = 32'd9; in_tag = 5'd20;
        tick(); tick(); tick();
        n_cmp++;
        if (stage_valid !== m_vec()) begin
            n_err++; $display("FAIL rst_fill: sv=%b want %b", stage_valid, m_vec());
        end
        rst_n = 1'b0;
        tick();
        n_cmp++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || out_result !== '0 || out_tag !== '0) begin
            n_err++;
            $display("FAIL rst_mid: ov=%b busy=%b res=%h tag=%0d want 0", out_valid, busy,
                     out_result, out_tag);
        end
        rst_n = 1'b1; out_ready = 1'b1; in_a = 32'd2; in_b = 32'd3; in_tag = 5'd9;
        tick();
        in_valid = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            if (out_valid && lat == 0) begin
                lat = k; n_cmp++;
                if (out_result !== 32'd6 || out_tag !== 5'd9) begin
                    n_err++; $display("FAIL rst_after: res=%0d tag=%0d want 6/9", out_result, out_tag);
                end
            end
            tick();
        end
        n_cmp++;
        if (lat != 2) begin n_err++; $display("FAIL rst_after_lat: got %0d want 2", lat); end
    endtask

    task automatic test_random();
        logic exp_rdy;
        for (int c = 0; c < 300; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            in_op     = 2'($urandom);
            in_tag    = 5'($urandom);
            case ($urandom_range(0, 3))
                0:       in_a = 32'hFFFF_FFFF;
                1:       in_a = 32'h8000_0000;
                default: in_a = $urandom;
            endcase
            in_b = ($urandom_range(0, 3) == 0) ? 32'h7FFF_FFFF : $urandom;
            #1;
            exp_rdy = !m_v[SM-1] || out_ready;
            n_cmp++;
            if (in_ready !== exp_rdy) begin
                n_err++; $display("FAIL rnd_in_ready c%0d: got %b want %b", c, in_ready, exp_rdy);
            end
            tick();
            n_cmp++;
            if (stage_valid !== m_vec() || busy !== (|m_vec()) || out_valid !== m_v[SM-1]) begin
                n_err++;
                $display("FAIL rnd_valid c%0d: sv=%b busy=%b ov=%b want sv=%b", c, stage_valid,
                         busy, out_valid, m_vec());
            end
            if (m_v[SM-1]) begin
                n_cmp++;
                if (out_result !== m_r[SM-1] || out_tag !== m_t[SM-1]) begin
                    n_err++;
                    $display("FAIL rnd_out c%0d: res=%h tag=%0d want %h/%0d", c, out_result,
                             out_tag, m_r[SM-1], m_t[SM-1]);
                end
            end
            for (int i = 0; i < int'(SM); i++) begin
                if (m_v[i]) begin
                    n_cmp++;
                    if (stage_tag[i*TW +: TW] !== m_t[i]) begin
                        n_err++;
                        $display("FAIL rnd_stage_tag%0d c%0d: got %0d want %0d", i, c,
                                 stage_tag[i*TW +: TW], m_t[i]);
                    end
                end
            end
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tick(); tick(); tick();
    endtask

    initial begin
        for (int i = 0; i < int'(SM); i++) begin
            m_v[i] = 1'b0; m_r[i] = '0; m_t[i] = '0;
        end
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_op = 2'b00; in_a = '0; in_b = '0; in_tag = '0;
        test_reset();
        test_latency();
        test_ops();
        test_backpressure();
        test_flush();
        test_reset_midop();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sr_mul_pipe.md
# sr_mul_pipe

Parametrised, elastic, pipelined integer multiplier for the schoolRISCV execute stage. It succeeds the fixed two-stage, low-half-only multiplier with:
- configurable width and depth;
- RV32M op select (MUL/MULH/MULHSU/MULHU);
- valid/ready backpressure, flush, and destination-tag passthrough;
- per-stage valid/tag visibility for the core's bypass and stall logic.

## Interface
- `WIDTH`, 32: operand and result width in bits (≥ 8).
- `STAGES`, 2: pipeline depth in register stages (≥ 1); equals latency without backpressure.
- `TAG_W`, 5: sideband tag width (destination register index).
- `clk`  in  1: clock. Single clock domain.
- `rst_n`  in  1: reset, synchronous, active-low.
- `flush`  in  1: discard all in-flight and same-cycle input operations.
- `in_valid`  in  1: input operation valid.
- `in_ready`  out  1: unit can accept input this cycle.
- `in_op`  in  2: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
- `in_a`, `in_b`  in  WIDTH: operands (rs1, rs2).
- `in_tag`  in  TAG_W: carried unchanged to the output.
- `out_valid`  out  1: result valid.
- `out_ready`  in  1: consumer accepts the result.
- `out_result`  out  WIDTH: product (half selected by op).
- `out_tag`  out  TAG_W: tag of the result.
- `stage_valid`  out  STAGES: valid bit of each stage; bit 0 = newest.
- `stage_tag`  out  STAGES*TAG_W: tag of each stage; slice i belongs to stage i.
- `busy`  out  1: OR of `stage_valid`.

## Operation
- Stage 0 registers the full signed product of (WIDTH+1)-bit extended operands. The result is 2*WIDTH+2 bits wide.
  - `in_a` is sign-extended for MULH and MULHSU, otherwise zero-extended.
  - `in_b` is sign-extended for MULH only.
- Stages 1..STAGES-1 carry product, op, tag and valid. Synthesis retiming may move the multiplier across them.
- Output selection is taken from the last stage:
  - MUL: bits [WIDTH-1:0].
  - All other ops: bits [2*WIDTH-1:WIDTH].
- Advance: `adv = !stage_valid[STAGES-1] | out_ready`. Stalls are global; every stage holds when `adv` = 0.
- `in_ready = adv`. The handshake is `in_valid & in_ready`. Bubbles are not compressed.
- On `adv`, stage 0 valid takes the handshake result, and each stage i takes stage i-1.
- `out_valid = stage_valid[STAGES-1]`.
- `out_result` and `out_tag` hold stable while `out_valid & !out_ready`.
- `flush` clears all valid bits on the next edge and overrides `adv` and the input handshake. Data registers are don't-care after flush.
- Operations leave strictly in issue order.

## Timing
- Latency: an operation accepted at edge N appears with `out_valid` after edge N+STAGES-1, i.e. STAGES cycles from issue. STAGES = 1 gives single-cycle registered output.
- Throughput: 1 op per cycle while `out_ready` = 1.
- Full pipe with `out_ready` = 0: `in_ready` = 0 in the same cycle (combinational from `out_ready`).
- `out_ready` rising while full: output retires, all stages shift, and a new input is accepted in the same cycle.
- Simultaneous `flush` and `out_ready`: flush wins. The output is discarded and the consumer must not also retire it.
- Reset values: all `stage_valid` 0, `out_valid` 0, `busy` 0, `out_result` 0, `out_tag` 0, `stage_tag` 0.
- Reset asserted mid-operation drops everything; there are no partial outputs.
- `in_ready` is 1 during reset, but no handshake completes while `rst_n` = 0.
- Overflow: MUL wraps modulo 2^WIDTH. High ops are exact; no saturation.

## Configuration
- `SR_MUL_HIGH_EN` defined: all four ops are supported as above.
- `SR_MUL_HIGH_EN` undefined:
  - `in_op` is ignored and every op behaves as MUL.
  - Operands are zero-extended, and only a WIDTH-bit product is registered (saves area).
  - Handshake, latency, tags and flush are unchanged.

## Structure
- Package `sr_mul_pkg` holds:
  - op encodings `MUL_OP_MUL/MULH/MULHSU/MULHU`;
  - the 2-bit op typedef;
  - the product-width constant `2*WIDTH+2`.
- Sub-module `sr_mul_stage` is one pipeline register slice (valid, tag, op, product, with hold and flush), instantiated STAGES-1 times via generate.
- Stage 0 product logic and output selection live in the top module.

## Test plan
- Latency: STAGES = 2, MUL 7×6, tag 3, `out_ready` = 1. `out_valid` is asserted 2 cycles after issue with result 42 and tag 3. Repeat for STAGES = 1 and STAGES = 4, expecting latency 1 and 4.
- Ops: a = b = 0xFFFFFFFF.
  - MUL → 0x00000001
  - MULH → 0x00000000
  - MULHSU → 0xFFFFFFFF
  - MULHU → 0xFFFFFFFE
- Backpressure: issue 5 ops (tags 1–5) back-to-back with `out_ready` = 0 for cycles 2–5.
  - `in_ready` drops once the pipe is full.
  - No op is lost or duplicated, and tags emerge in order 1–5.
  - `out_result` is stable while stalled.
- Flush: 2 ops in flight, `flush` asserted with `in_valid` = 1. Next cycle all `stage_valid` = 0, and no output appears for any of the 3 ops.
- Reset: `rst_n` low for 1 cycle with a full pipe. `out_valid`, `busy`, `out_result` and `out_tag` are 0 after the edge. A new MUL 2×3 then returns 6 with normal latency.
- Macro off: MULHU 0xFFFFFFFF×2 returns 0xFFFFFFFE (the low half); MUL 7×6 still returns 42.
